// File: rtl/pe_inst_issuer.sv
// PE column instruction issuer: per layer issues RESET, streams the packed Conf
// over the config bus, issues START, then WORK nwork times with STALL on backpressure.
module pe_inst_issuer #(
   parameter int ConfWd    = 80,
   parameter int ConfBusWd = 16,
   parameter int InstDWd   = 3,
   parameter int PEcol     = 16,
   parameter int CntWd     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [ConfWd-1:0]    i_conf,
   input  logic [CntWd-1:0]     i_nwork,
   input  logic [PEcol-1:0]     i_pe_mask,
   input  logic                 i_conf_valid,
   output logic                 o_conf_ready,
   input  logic [PEcol-1:0]     i_pe_ready,
   output logic [InstDWd-1:0]   o_inst,
   output logic [PEcol-1:0]     o_pe_en,
   output logic [ConfBusWd-1:0] o_cbus,
   output logic                 o_cbus_valid,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2:0]           dbg_state
);

   localparam int NBeat  = (ConfWd + ConfBusWd - 1) / ConfBusWd;
   localparam int PadWd  = NBeat * ConfBusWd;
   localparam int BeatWd = (NBeat > 1) ? $clog2(NBeat) : 1;
   localparam logic [BeatWd-1:0] LastBeat = BeatWd'(NBeat - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RST   = 3'd1;
   localparam logic [2:0] S_CONF  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_WORK  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [InstDWd-1:0] INST_STALL = InstDWd'(0);
   localparam logic [InstDWd-1:0] INST_RESET = InstDWd'(1);
   localparam logic [InstDWd-1:0] INST_START = InstDWd'(2);
   localparam logic [InstDWd-1:0] INST_WORK  = InstDWd'(3);

   logic [2:0]        state;
   logic [BeatWd-1:0] beat;
   logic [CntWd-1:0]  cnt;
   logic [PadWd-1:0]  conf_sh;
   logic [CntWd-1:0]  nwork_q;
   logic [PEcol-1:0]  mask_q;
   logic              go;

   // Handshake: a Conf word transfers on a cycle where i_conf_valid and
   // o_conf_ready are both high at the rising edge; ready is high only in IDLE
   // and never depends on valid.
   assign o_conf_ready = (state == S_IDLE);

   // Disabled PEs are forced ready so they never hold up the column.
   assign go = &(i_pe_ready | ~mask_q);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         beat    <= '0;
         cnt     <= '0;
         conf_sh <= '0;
         nwork_q <= '0;
         mask_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_conf_valid && o_conf_ready) begin
                  // Left-align so a short final beat is zero-padded in its low bits.
                  conf_sh <= PadWd'(i_conf) << (PadWd - ConfWd);
                  nwork_q <= i_nwork;
                  mask_q  <= i_pe_mask;
                  state   <= S_RST;
               end
            end
            S_RST: begin
               beat  <= '0;
               state <= S_CONF;
            end
            S_CONF: begin
               conf_sh <= conf_sh << ConfBusWd;
               if (beat == LastBeat) begin
                  beat  <= '0;
                  state <= S_START;
               end else begin
                  beat <= beat + BeatWd'(1);
               end
            end
            S_START: begin
               cnt   <= '0;
               state <= (nwork_q != '0) ? S_WORK : S_DONE;
            end
            S_WORK: begin
               if (go) begin
                  if (cnt == nwork_q - CntWd'(1)) begin
                     cnt   <= '0;
                     state <= S_DONE;
                  end else begin
                     cnt <= cnt + CntWd'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_inst = INST_STALL;
      case (state)
         S_RST:   o_inst = INST_RESET;
         S_START: o_inst = INST_START;
         S_WORK:  o_inst = go ? INST_WORK : INST_STALL;
         default: o_inst = INST_STALL;
      endcase
   end

   assign o_pe_en      = (state != S_IDLE) ? mask_q : '0;
   assign o_cbus       = (state == S_CONF) ? conf_sh[PadWd-1 -: ConfBusWd] : '0;
   assign o_cbus_valid = (state == S_CONF);
   assign o_busy       = (state != S_IDLE);
   assign o_done       = (state == S_DONE);
   assign dbg_state    = state;

endmodule

// File: tb/tb_pe_inst_issuer.sv
// Directed bench for pe_inst_issuer: a per-cycle vector table for the basic layer,
// plus hand-written sequences for stalls, masking, nwork=0, mid-layer reset and back-to-back layers.
module tb_pe_inst_issuer;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [15:0] ready;
      logic [2:0]  inst;
      logic [15:0] cbus;
      logic        cvalid;
      logic        busy;
      logic        done;
      logic        cready;
      logic [15:0] pe_en;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [79:0] conf;
   logic [15:0] nwork;
   logic [15:0] pe_mask;
   logic        conf_valid;
   logic        conf_ready;
   logic [15:0] pe_ready;
   logic [2:0]  inst;
   logic [15:0] pe_en;
   logic [15:0] cbus;
   logic        cbus_valid;
   logic        busy;
   logic        done;
   logic [2:0]  dbg_state;

   logic [79:0] cur_conf;
   logic [15:0] cur_nwork;
   logic [15:0] cur_mask;
   logic [15:0] cur_beats[5];
   int          checks = 0;
   int          errors = 0;
   int          row = 0;

   localparam logic [2:0] STALL = 3'd0, RESET = 3'd1, START = 3'd2, WORK = 3'd3;
   localparam logic [15:0] ALL = 16'hFFFF;

   pe_inst_issuer dut (
      .i_clk(clk), .i_rst(rst), .i_conf(conf), .i_nwork(nwork), .i_pe_mask(pe_mask),
      .i_conf_valid(conf_valid), .o_conf_ready(conf_ready), .i_pe_ready(pe_ready),
      .o_inst(inst), .o_pe_en(pe_en), .o_cbus(cbus), .o_cbus_valid(cbus_valid),
      .o_busy(busy), .o_done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic v, input logic [15:0] rdy,
                               input logic [2:0] in, input logic [15:0] cb, input logic cv,
                               input logic bz, input logic dn, input logic cr,
                               input logic [15:0] en);
      vec_t t;
      t.rst = r; t.valid = v; t.ready = rdy; t.inst = in; t.cbus = cb; t.cvalid = cv;
      t.busy = bz; t.done = dn; t.cready = cr; t.pe_en = en;
      return t;
   endfunction

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", what, row, act, exp);
      end
   endtask

   // One cycle: drive inputs after the falling edge, compare before the next rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; conf_valid = v.valid; pe_ready = v.ready;
      conf = cur_conf; nwork = cur_nwork; pe_mask = cur_mask;
      #1;
      check("inst", 32'(inst), 32'(v.inst));
      check("cbus", 32'(cbus), 32'(v.cbus));
      check("cbus_valid", 32'(cbus_valid), 32'(v.cvalid));
      check("busy", 32'(busy), 32'(v.busy));
      check("done", 32'(done), 32'(v.done));
      check("conf_ready", 32'(conf_ready), 32'(v.cready));
      check("pe_en", 32'(pe_en), 32'(v.pe_en));
      row++;
   endtask

   // IDLE accept cycle, RESET, five config beats and START for the current layer.
   task automatic head(input logic vbody, input logic [15:0] rdy);
      apply(mk(0, 1, rdy, STALL, 16'h0, 0, 0, 0, 1, 16'h0));
      apply(mk(0, vbody, rdy, RESET, 16'h0, 0, 1, 0, 0, cur_mask));
      for (int k = 0; k < 5; k++)
         apply(mk(0, vbody, rdy, STALL, cur_beats[k], 1, 1, 0, 0, cur_mask));
      apply(mk(0, vbody, rdy, START, 16'h0, 0, 1, 0, 0, cur_mask));
   endtask

   task automatic set_beats_a();
      cur_conf = 80'h0123_4567_89AB_CDEF_F00D;
      cur_beats = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hF00D};
   endtask

   vec_t tbl[13];

   initial begin
      set_beats_a();
      cur_nwork = 16'd3;
      cur_mask  = ALL;
      // Basic layer, one row per cycle: idle/accept, RESET, 5 beats, START, WORK x3, DONE, idle.
      tbl[0]  = mk(0, 1, ALL, STALL, 16'h0,    0, 0, 0, 1, 16'h0);
      tbl[1]  = mk(0, 0, ALL, RESET, 16'h0,    0, 1, 0, 0, ALL);
      tbl[2]  = mk(0, 0, ALL, STALL, 16'h0123, 1, 1, 0, 0, ALL);
      tbl[3]  = mk(0, 0, ALL, STALL, 16'h4567, 1, 1, 0, 0, ALL);
      tbl[4]  = mk(0, 0, ALL, STALL, 16'h89AB, 1, 1, 0, 0, ALL);
      tbl[5]  = mk(0, 0, ALL, STALL, 16'hCDEF, 1, 1, 0, 0, ALL);
      tbl[6]  = mk(0, 0, ALL, STALL, 16'hF00D, 1, 1, 0, 0, ALL);
      tbl[7]  = mk(0, 0, ALL, START, 16'h0,    0, 1, 0, 0, ALL);
      tbl[8]  = mk(0, 0, ALL, WORK,  16'h0,    0, 1, 0, 0, ALL);
      tbl[9]  = mk(0, 0, ALL, WORK,  16'h0,    0, 1, 0, 0, ALL);
      tbl[10] = mk(0, 0, ALL, WORK,  16'h0,    0, 1, 0, 0, ALL);
      tbl[11] = mk(0, 0, ALL, STALL, 16'h0,    0, 1, 1, 0, ALL);
      tbl[12] = mk(0, 0, ALL, STALL, 16'h0,    0, 0, 0, 1, 16'h0);

      // Reset: hold for two edges, then check the idle outputs while reset is still high.
      rst = 1; conf_valid = 0; pe_ready = ALL; conf = cur_conf; nwork = 0; pe_mask = ALL;
      repeat (2) @(posedge clk);
      apply(mk(1, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));
      check("dbg_state_reset", 32'(dbg_state), 32'd0);

      for (int i = 0; i < 13; i++) apply(tbl[i]);

      // PE 5 not ready for two WORK cycles: two STALLs inserted, still four WORKs.
      cur_nwork = 16'd4;
      head(0, ALL);
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, 16'hFFDF, STALL, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, 16'hFFDF, STALL, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 1, 1, 0, ALL));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));

      // Upper half disabled and never ready: no stalls.
      cur_nwork = 16'd3;
      cur_mask  = 16'h00FF;
      head(0, 16'h00FF);
      for (int k = 0; k < 3; k++)
         apply(mk(0, 0, 16'h00FF, WORK, 16'h0, 0, 1, 0, 0, 16'h00FF));
      apply(mk(0, 0, 16'h00FF, STALL, 16'h0, 0, 1, 1, 0, 16'h00FF));
      apply(mk(0, 0, 16'h00FF, STALL, 16'h0, 0, 0, 0, 1, 16'h0));

      // nwork = 0: START goes straight to DONE.
      cur_nwork = 16'd0;
      cur_mask  = ALL;
      head(0, ALL);
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 1, 1, 0, ALL));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));

      // Reset during the second WORK cycle aborts the layer.
      cur_nwork = 16'd5;
      head(0, ALL);
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(1, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));
      cur_nwork = 16'd1;
      head(0, ALL);
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 1, 1, 0, ALL));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));

      // Back-to-back layers with valid held high; the second Conf differs.
      cur_nwork = 16'd1;
      head(1, ALL);
      apply(mk(0, 1, ALL, WORK, 16'h0, 0, 1, 0, 0, ALL));
      cur_conf  = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
      cur_beats = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};
      cur_nwork = 16'd2;
      cur_mask  = 16'h0F0F;
      apply(mk(0, 1, ALL, STALL, 16'h0, 0, 1, 1, 0, ALL));
      head(0, ALL);
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, 16'h0F0F));
      apply(mk(0, 0, ALL, WORK, 16'h0, 0, 1, 0, 0, 16'h0F0F));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 1, 1, 0, 16'h0F0F));
      apply(mk(0, 0, ALL, STALL, 16'h0, 0, 0, 0, 1, 16'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_inst_issuer.md
Name: pe_inst_issuer

Overview:
- Initiator side of the PE column control interface: accepts one layer Conf word from the layer scheduler and drives the PE column.
- Per layer it issues RESET, serializes the packed Conf over a narrow config bus, issues START, then issues WORK for a programmed number of cycles. STALL is inserted whenever an enabled PE is not ready.
- Sits between the top-level layer scheduler and the PEcol-wide PE column; PEs are the receiving end.

Parameters:
- ConfWd, 80, width of the packed PECfg::Conf struct (Pch..Tw, MSB = Pch).
- ConfBusWd, 16, config bus width per beat.
- NBeat, ceil(ConfWd/ConfBusWd) = 5, beats per Conf transfer.
- InstDWd, 3, PE instruction width (PEiss encoding).
- PEcol, 16, PEs in the column.
- CntWd, 16, WORK count width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_conf  in  ConfWd  packed Conf for the next layer.
- i_nwork  in  CntWd  number of WORK instructions to issue for this layer.
- i_pe_mask  in  PEcol  enabled PEs for this layer (1 = enabled).
- i_conf_valid  in  1  upstream valid.
- o_conf_ready  out  1  upstream ready.
- i_pe_ready  in  PEcol  per-PE ready to accept WORK.
- o_inst  out  InstDWd  PEiss instruction: STALL=0, RESET=1, START=2, WORK=3.
- o_pe_en  out  PEcol  latched i_pe_mask, broadcast to the column.
- o_cbus  out  ConfBusWd  config beat data.
- o_cbus_valid  out  1  config beat valid.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse at end of layer.

Behaviour:
- Reset (i_rst=1 at a posedge):
  - state=IDLE, beat and WORK counters = 0, latched conf/nwork/mask = 0.
  - Outputs: o_inst=STALL, o_pe_en=0, o_cbus=0, o_cbus_valid=0, o_busy=0, o_done=0, o_conf_ready=1.
  - Reset mid-layer aborts immediately: the next cycle is IDLE, and no further RESET/WORK is issued.
- Output timing: all outputs are decodes of registered state and counters. The only combinational input path is i_pe_ready -> o_inst in WORK. There is no other input-to-output path.
- IDLE:
  - o_conf_ready=1.
  - On i_conf_valid & o_conf_ready, latch i_conf, i_nwork and i_pe_mask; next state RST.
- RST: one cycle, o_inst=RESET, o_pe_en=latched mask; next state CONF.
- CONF: NBeat cycles, o_cbus_valid=1.
  - Beat k (k=0..NBeat-1) carries conf[ConfWd-1-k*ConfBusWd -: ConfBusWd], MSB chunk first.
  - If ConfWd is not a multiple of ConfBusWd, the last beat is zero-padded in its low bits.
  - o_inst=STALL. After beat NBeat-1, next state START.
  - No backpressure on the config bus: PEs must sink one beat per cycle.
- START: one cycle, o_inst=START.
  - Next state WORK if nwork != 0, else DONE.
- WORK:
  - go = &(i_pe_ready | ~pe_en).
  - If go: o_inst=WORK and cnt++. Otherwise o_inst=STALL and cnt holds.
  - When go and cnt == nwork-1, next state DONE and cnt clears.
  - Exactly nwork WORK instructions are issued per layer.
  - Disabled PEs never stall the column. An all-zero mask makes go=1 every cycle.
- DONE: one cycle, o_done=1, o_inst=STALL; next state IDLE.
- Handshake:
  - o_conf_ready=0 in every state except IDLE.
  - A new Conf presented during DONE is accepted in the following IDLE cycle, so layers are back-to-back with a one-idle-cycle gap.
- o_pe_en holds the latched mask from RST through DONE and is 0 in IDLE.
- Counter width: cnt is CntWd bits, so nwork = 2^CntWd-1 is supported with no wrap.

Test Plan:
- Reset, then Conf = 80'h0123_4567_89AB_CDEF_F00D with nwork=3, mask=16'hFFFF, all ready -> o_inst sequence STALL(idle), RESET, STALL x5, START, WORK x3, STALL(done) with o_done=1. Beats on o_cbus: 0123, 4567, 89AB, CDEF, F00D.
- Same Conf, nwork=4; i_pe_ready[5]=0 for 2 cycles in the middle of WORK -> 2 STALL cycles inserted, still exactly 4 WORK, DONE 2 cycles later than the unstalled case.
- Mask=16'h00FF with i_pe_ready[15:8]=0 permanently -> no stalls; WORK issued every cycle; o_pe_en=00FF from RST through DONE.
- nwork=0 -> START is followed directly by DONE; zero WORK issued; o_done pulses once.
- Assert i_rst during the 2nd WORK cycle -> next cycle o_inst=STALL, o_busy=0, o_conf_ready=1, o_pe_en=0. A new Conf is then accepted normally.
- Hold i_conf_valid=1 for two back-to-back layers -> the second is accepted on the first IDLE after DONE; o_conf_ready is low throughout layer 1 except IDLE.
